uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmitter between up to NUM_REQ byte-stream requesters. It sits between the requester blocks and the uart module's tx_data / tx_data_strobe / tx_ready interface. It locks the transmitter to one requester from its first byte to its `last` byte, so packets never interleave. It paces strobes so the UART never receives a byte while its single-byte buffer is occupied, and it releases a stalled requester after a timeout.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT, 4000000: consecutive stalled cycles before a locked packet is abandoned; 0 disables the timeout.
- TIMEOUT_WIDTH, 23: width of the stall counter; must hold TIMEOUT.
- CLK_40  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high; clock CLK_40.
- req_data  in  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- req_valid  in  NUM_REQ  requester i presents a byte.
- req_last  in  NUM_REQ  byte presented by requester i ends its packet.
- req_ready  out  NUM_REQ  one-cycle accept pulse to requester i.
- uart_tx_data  out  8  to uart tx_data.
- uart_tx_data_strobe  out  1  to uart tx_data_strobe; one-cycle pulse.
- uart_tx_ready  in  1  from uart tx_ready.
- grant  out  NUM_REQ  one-hot current owner; all zero when unowned.
- busy  out  1  high in any state other than IDLE.
- timeout_event  out  1  one-cycle pulse when a lock is abandoned.

## Operation
- All outputs are registered. Reset values: req_ready=0, uart_tx_data=0, uart_tx_data_strobe=0, grant=0, busy=0, timeout_event=0, state=IDLE, rr_last=NUM_REQ-1, stall counter=0.
- IDLE: if any req_valid is high, grant the first valid index searching upward from rr_last+1 (mod NUM_REQ). Load grant one-hot, clear the stall counter, go to WAIT_READY. If none is valid, stay in IDLE.
- WAIT_READY: when uart_tx_ready=1 and req_valid[g]=1:
  - latch req_data[g] into uart_tx_data;
  - pulse uart_tx_data_strobe and req_ready[g];
  - latch req_last[g] into last_flag;
  - clear the stall counter and go to WAIT_ACK.
- WAIT_READY stall: while req_valid[g]=0, the stall counter increments. The counter does not advance while req_valid[g]=1 and uart_tx_ready=0.
- WAIT_READY timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT-1 with req_valid[g] still 0:
  - pulse timeout_event;
  - rr_last<=g and grant<=0;
  - go to IDLE.
- WAIT_ACK: wait until uart_tx_ready=0, which confirms the UART took the byte.
  - If last_flag=1, go to IDLE with rr_last<=g and grant<=0.
  - Otherwise return to WAIT_READY with the grant held.
- req_valid and req_last from non-granted requesters are ignored while a lock is held.
- req_data/req_valid/req_last of requester i must stay stable until req_ready[i] is seen. The requester may update them on that same edge.

## Timing
- Arbitration takes 1 cycle: IDLE→WAIT_READY on the edge after req_valid is sampled.
- Byte issue: on edge E0 (WAIT_READY condition met), strobe, req_ready and data are asserted. They deassert at E1.
- UART response: the UART samples the strobe at E1 and drops tx_ready at E1. The arbiter sees tx_ready=0 at E2 and leaves WAIT_ACK.
- No second strobe is issued before tx_ready has gone low and then high again. This makes the UART's drop of a strobe while its buffer is full unreachable.
- After reset, the UART holds tx_ready=0 until its first baud tick. The first byte waits in WAIT_READY and the stall counter does not run, because req_valid is high.
- Minimum gap between packets from different requesters: 1 IDLE cycle after the last byte's WAIT_ACK.
- Reset mid-packet: immediate return to reset values. A byte already strobed into the UART still transmits.
- Round-robin: rr_last is updated only on release (last byte or timeout), so a requester streaming packets cannot starve others.

## Test plan
- Single requester 0 sends a 3-byte packet 0x55,0xAA,0x0F with last on 0x0F, baud_rate=3 → UART tx_data sequence 0x55,0xAA,0x0F; exactly 3 req_ready[0] pulses; grant returns to 0 after the third byte.
- Requesters 1 and 2 both valid in IDLE after reset → req 1 granted first. After req 1's last byte, req 2 is granted, and the bytes never interleave.
- Requester 0 streams continuous 1-byte packets while req 3 is valid → grants alternate 0,3,0,3.
- TIMEOUT=16; requester 2 sends byte 0x11 (last=0), then drops valid → timeout_event pulses 16 cycles after entering WAIT_READY, grant=0, state IDLE; next arbitration starts at req 3.
- Strobe pacing: every strobe is separated by at least one cycle with uart_tx_ready=0 observed; an assertion checks no strobe is issued while the UART's internal buffer is full.
- Reset asserted in WAIT_ACK → all outputs 0 the same cycle; a fresh packet after deassertion transfers correctly.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter
// Locks the UART to one requester per packet and paces strobes on tx_ready handshakes.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT       = 4000000,
  parameter int TIMEOUT_WIDTH = 23
) (
  input  logic                   CLK_40,
  input  logic                   reset,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_data_strobe,
  input  logic                   uart_tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_event
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT_READY, WAIT_ACK} state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         gidx, gidx_n;
  logic [IDX_W-1:0]         rr_last, rr_last_n;
  logic [IDX_W-1:0]         cand;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt, stall_cnt_n;
  logic                     last_flag, last_flag_n;
  logic [NUM_REQ-1:0]       grant_n, req_ready_n;
  logic [7:0]               tx_data_n;
  logic                     strobe_n, timeout_n, found, g_valid;

  always_comb begin
    state_n     = state;
    gidx_n      = gidx;
    rr_last_n   = rr_last;
    stall_cnt_n = stall_cnt;
    last_flag_n = last_flag;
    grant_n     = grant;
    req_ready_n = '0;
    tx_data_n   = uart_tx_data;
    strobe_n    = 1'b0;
    timeout_n   = 1'b0;
    found       = 1'b0;
    cand        = '0;
    g_valid     = req_valid[gidx];

    case (state)
      IDLE: begin
        // Search upward starting just past the last released owner.
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IDX_W'((int'(rr_last) + k) % NUM_REQ);
          if (!found && req_valid[cand]) begin
            found  = 1'b1;
            gidx_n = cand;
          end
        end
        if (found) begin
          grant_n     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_n;
          stall_cnt_n = '0;
          state_n     = WAIT_READY;
        end
      end

      WAIT_READY: begin
        if (g_valid && uart_tx_ready) begin
          tx_data_n   = req_data[8*gidx +: 8];
          strobe_n    = 1'b1;
          req_ready_n = grant;
          last_flag_n = req_last[gidx];
          stall_cnt_n = '0;
          state_n     = WAIT_ACK;
        end else if (!g_valid && TIMEOUT != 0) begin
          if (stall_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
            timeout_n = 1'b1;
            rr_last_n = gidx;
            grant_n   = '0;
            state_n   = IDLE;
          end else begin
            stall_cnt_n = stall_cnt + 1'b1;
          end
        end
      end

      WAIT_ACK: begin
        // tx_ready falling is the UART's confirmation that it took the byte.
        if (!uart_tx_ready) begin
          if (last_flag) begin
            rr_last_n = gidx;
            grant_n   = '0;
            state_n   = IDLE;
          end else begin
            state_n = WAIT_READY;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      gidx                <= '0;
      rr_last             <= IDX_W'(NUM_REQ - 1);
      stall_cnt           <= '0;
      last_flag           <= 1'b0;
      grant               <= '0;
      req_ready           <= '0;
      uart_tx_data        <= '0;
      uart_tx_data_strobe <= 1'b0;
      timeout_event       <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state               <= state_n;
      gidx                <= gidx_n;
      rr_last             <= rr_last_n;
      stall_cnt           <= stall_cnt_n;
      last_flag           <= last_flag_n;
      grant               <= grant_n;
      req_ready           <= req_ready_n;
      uart_tx_data        <= tx_data_n;
      uart_tx_data_strobe <= strobe_n;
      timeout_event       <= timeout_n;
      busy                <= (state_n != IDLE);
    end
  end

endmodule
